// File: rtl/pio_tx_fifo.sv
// TX FIFO and pull controller for one PIO state machine, feeding the OSR.
// Handles bus pushes, explicit PULL / autopull pops, stall requests and sticky debug flags.
module pio_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        penable,
  input  logic                        join_tx,      // TX join mode ("join" is a reserved word)
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(2*DEPTH):0]    level,
  input  logic                        pull_req,
  input  logic                        pull_block,
  input  logic                        pull_ifempty,
  input  logic [WIDTH-1:0]            x_val,
  input  logic                        out_active,
  input  logic                        autopull_en,
  input  logic [4:0]                  pull_thresh,
  input  logic [5:0]                  shift_count,
  output logic                        osr_set,
  output logic [WIDTH-1:0]            osr_din,
  output logic                        stall,
  output logic                        txover,
  output logic                        txstall,
  input  logic                        clr_txover,
  input  logic                        clr_txstall
);

  localparam int PTR_W = $clog2(2 * DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [2*DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             join_q;
  logic [LVL_W-1:0] cap;
  logic             join_change;
  logic             push_ok, push_over;
  logic [5:0]       thr;
  logic             at_thr;
  logic             noop;
  logic             pop;
  logic             use_x;

  // Pointers wrap at the active capacity, not at the physical array size.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                               input logic [LVL_W-1:0] c);
    return ({1'b0, p} == c - LVL_W'(1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign cap         = join_q ? LVL_W'(2 * DEPTH) : LVL_W'(DEPTH);
  assign full        = (level == cap);
  assign empty       = (level == '0);
  assign join_change = (join_tx != join_q);
  assign push_ok     = push && !full && !join_change;
  assign push_over   = push && full && !join_change;

  assign thr    = (pull_thresh == 5'd0) ? 6'd32 : {1'b0, pull_thresh};
  assign at_thr = autopull_en && (shift_count >= thr);
  assign noop   = pull_req && pull_ifempty && autopull_en && !at_thr;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    osr_set = 1'b0;
    stall   = 1'b0;
    pop     = 1'b0;
    use_x   = 1'b0;
    if (penable && !noop) begin
      if (pull_req && !empty) begin
        osr_set = 1'b1;
        pop     = 1'b1;
      end else if (pull_req && pull_block) begin
        stall = 1'b1;
      end else if (pull_req) begin
        osr_set = 1'b1;
        use_x   = 1'b1;
      end else if (at_thr && !empty) begin
        osr_set = 1'b1;
        pop     = 1'b1;
      end else if (at_thr && out_active) begin
        stall = 1'b1;
      end
    end
    osr_din = use_x ? x_val : mem[rptr];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      join_q  <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      txover  <= 1'b0;
      txstall <= 1'b0;
    end else begin
      join_q <= join_tx;
      if (join_change) begin
        wptr  <= '0;
        rptr  <= '0;
        level <= '0;
      end else begin
        if (push_ok) wptr <= ptr_inc(wptr, cap);
        if (pop)     rptr <= ptr_inc(rptr, cap);
        case ({push_ok, pop})
          2'b10:   level <= level + LVL_W'(1);
          2'b01:   level <= level - LVL_W'(1);
          default: level <= level;
        endcase
      end
      // Clear wins over a same-cycle set.
      if (clr_txover)     txover <= 1'b0;
      else if (push_over) txover <= 1'b1;
      if (clr_txstall)    txstall <= 1'b0;
      else if (stall)     txstall <= 1'b1;
    end
  end

  // NOTE: the data array is not reset; the level and pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wptr] <= push_data;
  end

endmodule

// File: tb/tb_pio_tx_fifo.sv
// Directed self-checking bench for pio_tx_fifo (DEPTH=4, WIDTH=32).
module tb_pio_tx_fifo;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int LVL_W = $clog2(2*DEPTH) + 1;

  logic             clk, reset, penable, join_tx, push;
  logic [WIDTH-1:0] push_data, x_val, osr_din;
  logic             full, empty, pull_req, pull_block, pull_ifempty, out_active;
  logic [LVL_W-1:0] level;
  logic             autopull_en, osr_set, stall, txover, txstall, clr_txover, clr_txstall;
  logic [4:0]       pull_thresh;
  logic [5:0]       shift_count;

  int n_cmp = 0;
  int n_bad = 0;

  pio_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .penable(penable), .join_tx(join_tx),
    .push(push), .push_data(push_data), .full(full), .empty(empty), .level(level),
    .pull_req(pull_req), .pull_block(pull_block), .pull_ifempty(pull_ifempty),
    .x_val(x_val), .out_active(out_active), .autopull_en(autopull_en),
    .pull_thresh(pull_thresh), .shift_count(shift_count), .osr_set(osr_set),
    .osr_din(osr_din), .stall(stall), .txover(txover), .txstall(txstall),
    .clr_txover(clr_txover), .clr_txstall(clr_txstall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    penable = 1'b1; push = 1'b0; push_data = '0; pull_req = 1'b0; pull_block = 1'b0;
    pull_ifempty = 1'b0; x_val = '0; out_active = 1'b0; autopull_en = 1'b0;
    pull_thresh = 5'd0; shift_count = 6'd0; clr_txover = 1'b0; clr_txstall = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    join_tx = 1'b0; reset = 1'b1;
    push = 1'b1; push_data = 32'h99; pull_req = 1'b1; pull_block = 1'b1;
    tick(); tick();
    reset = 1'b0; idle(); #1;
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (txover !== 1'b0 || txstall !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got %b%b want 00", txover, txstall); end
    n_cmp++; if (osr_set !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL reset_osr_stall: got %b%b want 00", osr_set, stall); end
  endtask

  task automatic test_push_full();
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_data = 32'(32'hA1 + i); tick();
    end
    push = 1'b0; #1;
    n_cmp++; if (level !== 4'd4) begin n_bad++; $display("FAIL fill_level: got %0d want 4", level); end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b want 1", full); end
    push = 1'b1; push_data = 32'hA5; tick(); push = 1'b0; #1;
    n_cmp++; if (txover !== 1'b1) begin n_bad++; $display("FAIL overflow_txover: got %b want 1", txover); end
    n_cmp++; if (level !== 4'd4) begin n_bad++; $display("FAIL overflow_level: got %0d want 4", level); end
    clr_txover = 1'b1; tick(); clr_txover = 1'b0; #1;
    n_cmp++; if (txover !== 1'b0) begin n_bad++; $display("FAIL clr_txover: got %b want 0", txover); end
  endtask

  // Full FIFO: push 0xBB plus autopull pop in one cycle. Push dropped, oldest popped.
  task automatic test_overflow_autopull();
    logic [WIDTH-1:0] exp_q [3];
    exp_q[0] = 32'hA2; exp_q[1] = 32'hA3; exp_q[2] = 32'hA4;
    push = 1'b1; push_data = 32'hBB;
    autopull_en = 1'b1; pull_thresh = 5'd0; shift_count = 6'd32; #1;
    n_cmp++; if (osr_set !== 1'b1 || osr_din !== 32'hA1) begin n_bad++; $display("FAIL ovpop_osr: got %b/%h want 1/a1", osr_set, osr_din); end
    tick();
    push = 1'b0; autopull_en = 1'b0; #1;
    n_cmp++; if (level !== 4'd3) begin n_bad++; $display("FAIL ovpop_level: got %0d want 3", level); end
    n_cmp++; if (txover !== 1'b1) begin n_bad++; $display("FAIL ovpop_txover: got %b want 1", txover); end
    pull_req = 1'b1; pull_block = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (osr_set !== 1'b1 || osr_din !== exp_q[i]) begin n_bad++; $display("FAIL drain_%0d: got %b/%h want 1/%h", i, osr_set, osr_din, exp_q[i]); end
      tick();
    end
    pull_req = 1'b0; pull_block = 1'b0; #1;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty: got %b want 1", empty); end
    clr_txover = 1'b1; tick(); clr_txover = 1'b0;
  endtask

  task automatic test_join();
    join_tx = 1'b1; tick();
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; push_data = 32'(32'h100 + i); tick();
    end
    push = 1'b0; #1;
    n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL join_level: got %0d want 8", level); end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL join_full: got %b want 1", full); end
    join_tx = 1'b0; push = 1'b1; push_data = 32'hEE; tick(); push = 1'b0; #1;
    n_cmp++; if (level !== 4'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL join_flush: got level %0d empty %b want 0/1", level, empty); end
    n_cmp++; if (txover !== 1'b0) begin n_bad++; $display("FAIL join_no_txover: got %b want 0", txover); end
  endtask

  task automatic test_pull_block_empty();
    pull_req = 1'b1; pull_block = 1'b1; #1;
    n_cmp++; if (stall !== 1'b1 || osr_set !== 1'b0) begin n_bad++; $display("FAIL blk_stall: got stall %b osr_set %b want 1/0", stall, osr_set); end
    tick();
    n_cmp++; if (txstall !== 1'b1) begin n_bad++; $display("FAIL blk_txstall: got %b want 1", txstall); end
    clr_txstall = 1'b1; tick(); clr_txstall = 1'b0; #1;
    n_cmp++; if (txstall !== 1'b0) begin n_bad++; $display("FAIL clr_priority: got %b want 0", txstall); end
    push = 1'b1; push_data = 32'h1234; #1;
    n_cmp++; if (stall !== 1'b1 || osr_set !== 1'b0) begin n_bad++; $display("FAIL no_bypass: got stall %b osr_set %b want 1/0", stall, osr_set); end
    tick(); push = 1'b0; #1;
    n_cmp++; if (osr_set !== 1'b1 || osr_din !== 32'h1234 || stall !== 1'b0) begin n_bad++; $display("FAIL blk_load: got %b/%h/%b want 1/1234/0", osr_set, osr_din, stall); end
    tick(); pull_req = 1'b0; pull_block = 1'b0; #1;
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL blk_level: got %0d want 0", level); end
    clr_txstall = 1'b1; tick(); clr_txstall = 1'b0;
  endtask

  task automatic test_pull_nonblock();
    pull_req = 1'b1; pull_block = 1'b0; x_val = 32'hDEADBEEF; #1;
    n_cmp++; if (osr_set !== 1'b1 || osr_din !== 32'hDEADBEEF || stall !== 1'b0) begin n_bad++; $display("FAIL nb_load: got %b/%h/%b want 1/deadbeef/0", osr_set, osr_din, stall); end
    tick(); pull_req = 1'b0; #1;
    n_cmp++; if (level !== 4'd0 || txstall !== 1'b0) begin n_bad++; $display("FAIL nb_state: got level %0d txstall %b want 0/0", level, txstall); end
  endtask

  task automatic test_autopull();
    push = 1'b1; push_data = 32'h55; tick(); push = 1'b0;
    autopull_en = 1'b1; pull_thresh = 5'd0; shift_count = 6'd32; #1;
    n_cmp++; if (osr_set !== 1'b1 || osr_din !== 32'h55) begin n_bad++; $display("FAIL ap_32: got %b/%h want 1/55", osr_set, osr_din); end
    tick(); autopull_en = 1'b0; #1;
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL ap_pop: got empty %b want 1", empty); end
    push = 1'b1; push_data = 32'h56; tick(); push = 1'b0;
    autopull_en = 1'b1; shift_count = 6'd31; #1;
    n_cmp++; if (osr_set !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL ap_31: got %b/%b want 0/0", osr_set, stall); end
    tick();
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL ap_31_level: got %0d want 1", level); end
    pull_thresh = 5'd8; shift_count = 6'd8; #1;
    n_cmp++; if (osr_set !== 1'b1 || osr_din !== 32'h56) begin n_bad++; $display("FAIL ap_thr8: got %b/%h want 1/56", osr_set, osr_din); end
    tick(); out_active = 1'b1; #1;
    n_cmp++; if (stall !== 1'b1 || osr_set !== 1'b0) begin n_bad++; $display("FAIL ap_empty_stall: got %b/%b want 1/0", stall, osr_set); end
    tick();
    n_cmp++; if (txstall !== 1'b1) begin n_bad++; $display("FAIL ap_txstall: got %b want 1", txstall); end
    out_active = 1'b0; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ap_no_out: got %b want 0", stall); end
    idle(); clr_txstall = 1'b1; tick(); clr_txstall = 1'b0;
  endtask

  task automatic test_noop_penable();
    push = 1'b1; push_data = 32'h77; tick();
    push_data = 32'h78; tick(); push = 1'b0;
    pull_req = 1'b1; pull_ifempty = 1'b1; autopull_en = 1'b1; shift_count = 6'd5; #1;
    n_cmp++; if (osr_set !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL ifempty_noop: got %b/%b want 0/0", osr_set, stall); end
    tick();
    n_cmp++; if (level !== 4'd2) begin n_bad++; $display("FAIL ifempty_level: got %0d want 2", level); end
    idle(); penable = 1'b0; pull_req = 1'b1; push = 1'b1; push_data = 32'h79; #1;
    n_cmp++; if (osr_set !== 1'b0) begin n_bad++; $display("FAIL pen0_osr: got %b want 0", osr_set); end
    tick(); push = 1'b0;
    n_cmp++; if (level !== 4'd3) begin n_bad++; $display("FAIL pen0_level: got %0d want 3", level); end
    penable = 1'b1; #1;
    n_cmp++; if (osr_set !== 1'b1 || osr_din !== 32'h77) begin n_bad++; $display("FAIL pen1_pull: got %b/%h want 1/77", osr_set, osr_din); end
    tick(); idle();
  endtask

  initial begin
    test_reset();
    test_push_full();
    test_overflow_autopull();
    test_join();
    test_pull_block_empty();
    test_pull_nonblock();
    test_autopull();
    test_noop_penable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pio_tx_fifo.md
Name: pio_tx_fifo

Overview:
TX FIFO and pull controller for one PIO state machine, directly upstream of the output shift register (OSR). Buffers 32-bit words pushed by the system bus and delivers them to the OSR on explicit PULL instructions or on autopull. Drives the OSR load strobe and data, and the state-machine stall request. Tracks the sticky TX overflow and TX stall debug flags.

Parameters:
DEPTH, 4, entries in normal mode; joined mode gives 2*DEPTH entries; must be a power of two
WIDTH, 32, data word width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
penable  in  1  state-machine clock-divider enable; pops and flag updates on the pull side occur only when high
join  in  1  1 = TX joined (capacity 2*DEPTH), 0 = capacity DEPTH
push  in  1  bus write strobe, single cycle
push_data  in  WIDTH  bus write data
full  out  1  level == capacity
empty  out  1  level == 0
level  out  $clog2(2*DEPTH)+1  current occupancy
pull_req  in  1  PULL instruction executing this cycle
pull_block  in  1  PULL block bit
pull_ifempty  in  1  PULL IfEmpty bit
x_val  in  WIDTH  scratch X, loaded on a non-blocking pull from an empty FIFO
out_active  in  1  OUT instruction executing this cycle
autopull_en  in  1  autopull enable
pull_thresh  in  5  autopull threshold; 0 means 32
shift_count  in  6  OSR shift count (0..32)
osr_set  out  1  OSR load strobe (combinational)
osr_din  out  WIDTH  OSR load data (combinational)
stall  out  1  state machine must stall this cycle (combinational)
txover  out  1  sticky: push to a full FIFO
txstall  out  1  sticky: stall on an empty FIFO
clr_txover  in  1  clears txover
clr_txstall  in  1  clears txstall

Behaviour:
- Storage: 2*DEPTH x WIDTH circular array. Read and write pointers have log2(2*DEPTH) bits and wrap modulo the active capacity. The level counter is registered.
- thr = (pull_thresh == 0) ? 32 : pull_thresh. at_thr = autopull_en && shift_count >= thr.
- Join change: join is registered to join_q. When join != join_q, pointers and level flush to 0 on that clock edge. Any push in the same cycle is dropped, and txover is not set.
- Push: accepted when push && level < capacity; data is written at wptr. If push && full, data is dropped and txover is set. A push is judged against the level at the start of the cycle; a pop in the same cycle does not free space for it.
- Pull-side decode, evaluated only when penable, first matching case wins:
  - pull_req && pull_ifempty && autopull_en && !at_thr: no-op. No osr_set, no stall.
  - pull_req && !empty: osr_set=1, osr_din=head, pop.
  - pull_req && empty && pull_block: stall=1, txstall set.
  - pull_req && empty && !pull_block: osr_set=1, osr_din=x_val, no pop.
  - !pull_req && at_thr && !empty: autopull. osr_set=1, osr_din=head, pop.
  - !pull_req && at_thr && empty && out_active: stall=1, txstall set.
  - Otherwise: osr_set=0, stall=0.
- There is no bypass: a word pushed in cycle N is visible to the pull side in cycle N+1. A simultaneous push and pull on an empty FIFO stalls that cycle.
- Simultaneous accepted push and pop: level is unchanged and both pointers advance.
- When penable=0: osr_set=0, stall=0, no pop, and sticky flags do not change from the pull side. Pushes are still accepted.
- osr_din is head whenever no case drives it otherwise. It is x_val only in the non-blocking-empty case.
- Sticky flags: a clear has priority over a set in the same cycle.
- Reset: pointers=0, level=0, join_q=0, txover=0, txstall=0. Outputs after reset: empty=1, full=0, level=0, osr_set=0, stall=0. Reset overrides any concurrent push or pull.

Test Plan:
- Reset, then push 0xA1..0xA4 with join=0 -> full=1, level=4; a fifth push of 0xA5 is dropped and sets txover=1; clr_txover clears it.
- join=1, push 8 words -> level=8, full=1. Toggle join to 0 -> next cycle level=0, empty=1.
- Empty FIFO, pull_req with pull_block=1 -> stall=1, txstall=1, osr_set=0. Push 0x1234, next cycle pull_req -> osr_set=1, osr_din=0x1234, level=0.
- Empty FIFO, pull_req with pull_block=0 and x_val=0xDEADBEEF -> osr_set=1, osr_din=0xDEADBEEF, stall=0, level stays 0.
- autopull_en=1, pull_thresh=0, shift_count=32, FIFO holds 0x55 -> osr_set=1, osr_din=0x55. Repeat with shift_count=31 -> no load. Repeat with an empty FIFO and out_active=1 -> stall=1.
- FIFO full (level=4), push and autopull pop in the same cycle -> push dropped, txover=1, level=3; the popped word is the oldest entry.
